exp_shifter_gen: RTL and testbench
==================================

EXP_SHIFTER_GEN -- requirements
Module: exp_shifter_gen

Interface
REQ-001 Parameter DATA_W, 16: width of each I and Q sample, signed.
REQ-002 Parameter TUSER_W, 24: tuser width; the MSB is the end-of-burst flag.
REQ-003 Parameter BIN_W, 9: FFT bin index at tuser[BIN_W-1:0].
REQ-004 Parameter EXP_LSB, 16: lowest bit of the exponent field in tuser.
REQ-005 Parameter EXP_W, 5: signed block-exponent width.
REQ-006 Parameter FRAC_W, 8: fractional bits in the exponent average.
REQ-007 Parameter HEAD_ROOM, 2: unsigned shift backoff.
REQ-008 Parameter MAX_SHIFT, 7: shift magnitude clamp, at most DATA_W-1.
REQ-009 clk  in  1  sole clock; one clock, reset is synchronous and active-low.
REQ-010 sync_reset_n  in  1  synchronous active-low reset.
REQ-011 s_axis_tvalid/tready/tlast  in/out/in  1  input AXI-Stream handshake.
REQ-012 s_axis_tdata  in  2*DATA_W  {I,Q}, I in the upper half.
REQ-013 s_axis_tuser  in  TUSER_W  bin index, exponent, eob.
REQ-014 alpha  in  4  IIR smoothing shift, 0..15; sampled at bin 0.
REQ-015 bypass  in  1  forces shift 0; sampled at bin 0.
REQ-016 m_axis_tvalid/tready/tlast  out/in/out  1  output handshake.
REQ-017 m_axis_tdata  out  2*DATA_W  shifted {I,Q}.
REQ-018 m_axis_tuser  out  TUSER_W  input tuser, passed through with the beat.
REQ-019 eob_tag  out  1  m_axis_tuser[TUSER_W-1].
REQ-020 cur_shift  out  EXP_W+2  signed shift applied to the frame now in stage 2.
REQ-021 sat_flag  out  1  high for one cycle with each output beat in which I or Q saturated.

Function
REQ-022 The datapath SHALL be a two-stage pipeline (S1, S2) with advance = !m_axis_tvalid || m_axis_tready, and s_axis_tready = advance, which is a combinational path.
REQ-023 With tready held high, each beat SHALL appear at the output exactly 2 cycles after acceptance; order, tlast and tuser SHALL be preserved, and no beat SHALL be dropped or duplicated.
REQ-024 A beat with bin index 0 SHALL mark a frame start; S1 SHALL latch a new shift on that beat and hold it for every following beat until the next bin-0 beat.
REQ-025 Exponent e = signed tuser[EXP_LSB+EXP_W-1:EXP_LSB]; the average register is signed, EXP_W+FRAC_W+1 bits, in units of 2^-FRAC_W.
REQ-026 Shift on a bin-0 beat: s = e - round_half_up(avg) - HEAD_ROOM, using avg before the update, clamped to ±MAX_SHIFT; s = 0 when bypass = 1.
REQ-027 Average update on a bin-0 beat: avg <= avg + (((e<<FRAC_W) - avg) >>> alpha); alpha = 0 SHALL make avg equal e.
REQ-028 Priming: the first bin-0 beat after reset SHALL load avg = e<<FRAC_W without filtering, and that beat SHALL use s = -HEAD_ROOM.
REQ-029 Beats accepted before the first bin-0 beat after reset SHALL pass with s = 0.
REQ-030 When s > 0, S2 SHALL left-shift and saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1], asserting sat_flag.
REQ-031 When s < 0, S2 SHALL compute (x + 2^(|s|-1)) >>> |s| in DATA_W+1 bits, which cannot overflow; s = 0 SHALL pass the sample unchanged.
REQ-032 While stalled (advance = 0), all pipeline registers, avg and the latched shift SHALL hold.
REQ-033 alpha and bypass changes between bin-0 beats SHALL have no effect until the next bin-0 beat.

Reset
REQ-034 While sync_reset_n = 0 at a clk edge, the block SHALL clear m_axis_tvalid, sat_flag, cur_shift, avg and the primed flag, and the latched shift SHALL go to 0.
REQ-035 A reset mid-frame SHALL discard the in-flight beats, and the next frame SHALL re-prime.
REQ-036 m_axis_tdata, m_axis_tuser and m_axis_tlast are don't-care while m_axis_tvalid = 0.

Structure
REQ-037 Package exp_shifter_pkg SHALL hold the round_half_up and saturate functions and the default parameter constants.
REQ-038 The shift-and-saturate logic SHALL be one sub-module, iq_barrel_sat, instantiated once per rail.

Verification (DATA_W=16, HEAD_ROOM=2, MAX_SHIFT=7, FRAC_W=8)
REQ-039 Reset, then a frame with e=5, alpha=0, I=0x1000 -> s=-2, I out 0x0400 two cycles after acceptance.
REQ-040 I=0x0003 and I=-0x0003 with s=-2 -> outputs 0x0001 and 0xFFFF (round half up).
REQ-041 Primed with e=0, alpha=4, then a frame with e=12 and I=0x0400 -> s clamped to 7, I out 0x7FFF, sat_flag=1; avg becomes 0x0C0 (0.75).
REQ-042 A 512-beat frame with m_axis_tready low for 5 cycles at beat 100 -> all 512 beats out in order, tlast on the last beat, s_axis_tready low during the stall.
REQ-043 sync_reset_n low for 1 cycle at beat 50 -> m_axis_tvalid=0 on the next cycle; the following frame with e=3 gives s=-2.
REQ-044 bypass=1 at bin 0 with e=9 -> data unchanged for the whole frame, cur_shift=0.

Source files
------------

// File: rtl/exp_shifter_pkg.sv
// Shared constants and arithmetic helpers for the block-exponent shifter.
package exp_shifter_pkg;

    localparam int DATA_W_DEF    = 16;
    localparam int TUSER_W_DEF   = 24;
    localparam int BIN_W_DEF     = 9;
    localparam int EXP_LSB_DEF   = 16;
    localparam int EXP_W_DEF     = 5;
    localparam int FRAC_W_DEF    = 8;
    localparam int HEAD_ROOM_DEF = 2;
    localparam int MAX_SHIFT_DEF = 7;

    // Fixed-point value with frac_w fractional bits, rounded to integer, ties toward +inf.
    function automatic int round_half_up(input int v, input int frac_w);
        return (v + (1 <<< (frac_w - 1))) >>> frac_w;
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/exp_shifter_gen_iq_barrel_sat.sv
// One rail of the S2 datapath: signed shift, saturating left / rounding right.
module iq_barrel_sat
    import exp_shifter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SH_W   = EXP_W_DEF + 2
) (
    input  logic signed [DATA_W-1:0] x_i,
    input  logic signed [SH_W-1:0]   shift_i,
    output logic signed [DATA_W-1:0] y_o,
    output logic                     sat_o
);

    logic signed [63:0] xw, lw, sw, rw, rnd;
    logic               neg;
    int                 amt;

    always_comb begin
        neg = shift_i[SH_W-1];
        amt = neg ? -int'(shift_i) : int'(shift_i);
        xw  = {{(64-DATA_W){x_i[DATA_W-1]}}, x_i};
        lw  = xw <<< amt;
        sw  = saturate(lw, DATA_W);
        rnd = (amt > 0) ? (64'sd1 <<< (amt - 1)) : 64'sd0;
        // Wide intermediate means the rounding add can never wrap.
        rw  = (xw + rnd) >>> amt;
        y_o   = x_i;
        sat_o = 1'b0;
        if (amt != 0) begin
            if (neg) begin
                y_o = DATA_W'(rw);
            end else begin
                y_o   = DATA_W'(sw);
                sat_o = (sw != lw);
            end
        end
    end

endmodule

// File: rtl/exp_shifter_gen.sv
// Two-stage AXI-Stream I/Q scaler: per-frame shift derived from a smoothed block exponent.
module exp_shifter_gen
    import exp_shifter_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int TUSER_W   = TUSER_W_DEF,
    parameter int BIN_W     = BIN_W_DEF,
    parameter int EXP_LSB   = EXP_LSB_DEF,
    parameter int EXP_W     = EXP_W_DEF,
    parameter int FRAC_W    = FRAC_W_DEF,
    parameter int HEAD_ROOM = HEAD_ROOM_DEF,
    parameter int MAX_SHIFT = MAX_SHIFT_DEF
) (
    input  logic                    clk,
    input  logic                    sync_reset_n,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic [2*DATA_W-1:0]     s_axis_tdata,
    input  logic [TUSER_W-1:0]      s_axis_tuser,
    input  logic [3:0]              alpha,
    input  logic                    bypass,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [2*DATA_W-1:0]     m_axis_tdata,
    output logic [TUSER_W-1:0]      m_axis_tuser,
    output logic                    eob_tag,
    output logic signed [EXP_W+1:0] cur_shift,
    output logic                    sat_flag
);

    localparam int SH_W  = EXP_W + 2;
    localparam int AVG_W = EXP_W + FRAC_W + 1;

    logic [1:0]                  vld_pipe_q;   // [0] = S1, [1] = S2
    logic                        advance, acc, bin0;
    logic signed [EXP_W-1:0]     e;
    logic signed [AVG_W-1:0]     avg_q, avg_d;
    logic                        primed_q, primed_d;
    logic signed [SH_W-1:0]      shift_q, shift_d, s1_shift_q, cur_shift_q;
    logic [1:0][DATA_W-1:0]      s1_data_q, m_data_q, rail_y;
    logic [TUSER_W-1:0]          s1_user_q, m_user_q;
    logic                        s1_last_q, m_last_q, sat_q;
    logic [1:0]                  rail_sat;
    int                          ei, ai, s_new, diff;

    assign advance       = !vld_pipe_q[1] || m_axis_tready;
    assign s_axis_tready = advance;
    assign acc           = advance && s_axis_tvalid;
    assign bin0          = (s_axis_tuser[BIN_W-1:0] == '0);
    assign e             = s_axis_tuser[EXP_LSB +: EXP_W];

    always_comb begin
        avg_d    = avg_q;
        primed_d = primed_q;
        shift_d  = shift_q;
        ei       = int'(e);
        ai       = int'(avg_q);
        s_new    = 0;
        diff     = 0;
        if (acc && bin0) begin
            if (!primed_q) begin
                // First frame seeds the average directly instead of filtering from zero.
                s_new    = -HEAD_ROOM;
                avg_d    = AVG_W'(ei <<< FRAC_W);
                primed_d = 1'b1;
            end else begin
                s_new = ei - round_half_up(ai, FRAC_W) - HEAD_ROOM;
                if (s_new > MAX_SHIFT)       s_new = MAX_SHIFT;
                else if (s_new < -MAX_SHIFT) s_new = -MAX_SHIFT;
                diff  = (ei <<< FRAC_W) - ai;
                avg_d = AVG_W'(ai + (diff >>> alpha));
            end
            if (bypass) s_new = 0;
            shift_d = SH_W'(s_new);
        end
    end

    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            vld_pipe_q  <= '0;
            avg_q       <= '0;
            primed_q    <= 1'b0;
            shift_q     <= '0;
            s1_shift_q  <= '0;
            cur_shift_q <= '0;
            sat_q       <= 1'b0;
        end else if (advance) begin
            vld_pipe_q <= {vld_pipe_q[0], s_axis_tvalid};
            avg_q      <= avg_d;
            primed_q   <= primed_d;
            shift_q    <= shift_d;
            s1_shift_q <= shift_d;
            sat_q      <= vld_pipe_q[0] && (|rail_sat);
            if (vld_pipe_q[0]) cur_shift_q <= s1_shift_q;
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            s1_data_q <= s_axis_tdata;
            s1_user_q <= s_axis_tuser;
            s1_last_q <= s_axis_tlast;
            m_data_q  <= rail_y;
            m_user_q  <= s1_user_q;
            m_last_q  <= s1_last_q;
        end
    end

    for (genvar r = 0; r < 2; r++) begin : g_rail
        iq_barrel_sat #(.DATA_W(DATA_W), .SH_W(SH_W)) u_sat (
            .x_i     (s1_data_q[r]),
            .shift_i (s1_shift_q),
            .y_o     (rail_y[r]),
            .sat_o   (rail_sat[r])
        );
    end

    assign m_axis_tvalid = vld_pipe_q[1];
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tuser  = m_user_q;
    assign m_axis_tlast  = m_last_q;
    assign eob_tag       = m_user_q[TUSER_W-1];
    assign cur_shift     = cur_shift_q;
    assign sat_flag      = sat_q;

endmodule

// File: tb/tb_exp_shifter_gen.sv
// Directed bench for exp_shifter_gen with hand-computed expected beats.
module tb_exp_shifter_gen;

    localparam int DW = 16;
    localparam int TW = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
    logic [2*DW-1:0] s_tdata = '0;
    logic [TW-1:0] s_tuser = '0;
    logic [3:0]    alpha = 4'd0;
    logic          bypass = 1'b0;
    logic          m_tvalid, m_tready = 1'b1, m_tlast;
    logic [2*DW-1:0] m_tdata;
    logic [TW-1:0] m_tuser;
    logic          eob;
    logic [6:0]    cur_shift;
    logic          sat;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] q_data[$];
    logic [1:0]  q_last[$];
    logic        q_sat[$];
    logic [6:0]  q_sh[$];

    always #5 clk = ~clk;

    exp_shifter_gen dut (
        .clk           (clk),
        .sync_reset_n  (rst_n),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .s_axis_tdata  (s_tdata),
        .s_axis_tuser  (s_tuser),
        .alpha         (alpha),
        .bypass        (bypass),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tuser  (m_tuser),
        .eob_tag       (eob),
        .cur_shift     (cur_shift),
        .sat_flag      (sat)
    );

    // Output monitor: one entry per completed output handshake.
    always @(negedge clk) begin
        if (rst_n && m_tvalid && m_tready) begin
            q_data.push_back(m_tdata);
            q_last.push_back({m_tlast, eob});
            q_sat.push_back(sat);
            q_sh.push_back(cur_shift);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear();
        q_data.delete(); q_last.delete(); q_sat.delete(); q_sh.delete();
    endtask

    task automatic expect_beat(input string tag, input logic [31:0] d, input logic last,
                               input logic s, input logic [6:0] sh);
        chk({tag, "_avail"}, q_data.size() > 0, 1);
        if (q_data.size() > 0) begin
            chk({tag, "_data"}, q_data.pop_front(), d);
            chk({tag, "_last"}, q_last.pop_front(), {last, last});
            chk({tag, "_sat"},  q_sat.pop_front(), s);
            chk({tag, "_shift"}, q_sh.pop_front(), sh);
        end
    endtask

    task automatic drive(input int bin, input int e, input logic [15:0] i,
                         input logic [15:0] q, input logic last);
        bit ok;
        s_tvalid = 1'b1;
        s_tlast  = last;
        s_tdata  = {i, q};
        s_tuser  = '0;
        s_tuser[8:0]   = 9'(bin);
        s_tuser[20:16] = 5'(e);
        s_tuser[23]    = last;
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk); ok = s_tready;
            @(posedge clk); #1;
        end
        if (!ok) chk("drive_timeout", ok, 1);
        s_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; s_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        chk("rst_mvalid", m_tvalid, 0);
        chk("rst_sat", sat, 0);
        chk("rst_shift", cur_shift, 0);
        chk("rst_sready", s_tready, 1);

        // Beats before first bin 0 pass unshifted
        drive(5, 0, 16'h1234, 16'h00AB, 0); idle(3);
        expect_beat("preprime", 32'h123400AB, 0, 0, 7'h00);

        // Priming frame e=5: s=-2, two-cycle latency
        drive(0, 5, 16'h1000, 16'h0800, 0);
        chk("lat_s1", m_tvalid, 0);
        @(posedge clk); #1;
        chk("lat_s2", m_tvalid, 1);
        chk("lat_data", m_tdata, 32'h04000200);
        chk("lat_shift", cur_shift, 7'h7E);
        chk("lat_tuser", m_tuser, 24'h050000);
        drive(1, 5, 16'h0003, 16'hFFFD, 0);
        drive(2, 5, 16'hFFFD, 16'h0003, 1);
        idle(4);
        expect_beat("prime5", 32'h04000200, 0, 0, 7'h7E);
        expect_beat("rnd_pos", 32'h0001FFFF, 0, 0, 7'h7E);
        expect_beat("rnd_neg", 32'hFFFF0001, 1, 0, 7'h7E);

        // e=8 vs avg=5: s=+1, Q=-0x4000 lands exactly on the negative rail
        drive(0, 8, 16'h1000, 16'hC000, 1); idle(4);
        expect_beat("shl1", 32'h20008000, 1, 0, 7'h01);

        // Clamp and saturation with alpha=4
        do_reset(); clear(); alpha = 4'd4;
        drive(0, 0, 16'h0008, 16'h0000, 1); idle(4);
        expect_beat("prime0", 32'h00020000, 1, 0, 7'h7E);
        drive(0, 12, 16'h0400, 16'hFC00, 0);
        drive(1, 12, 16'h0010, 16'h0000, 1);
        idle(4);
        expect_beat("clamp_sat", 32'h7FFF8000, 0, 1, 7'h07);
        expect_beat("clamp_nosat", 32'h08000000, 1, 0, 7'h07);
        // avg=0xC0 rounds to 1, so e=3 gives s=0
        drive(0, 3, 16'h1234, 16'h8001, 1); idle(4);
        expect_beat("avg_c0", 32'h12348001, 1, 0, 7'h00);

        // Bypass sampled at bin 0; mid-frame change ignored
        alpha = 4'd0; bypass = 1'b1;
        drive(0, 9, 16'h1234, 16'h8001, 0);
        bypass = 1'b0;
        drive(1, 9, 16'h7FFF, 16'h0003, 1);
        idle(4);
        expect_beat("byp0", 32'h12348001, 0, 0, 7'h00);
        expect_beat("byp1", 32'h7FFF0003, 1, 0, 7'h00);
        // alpha=0 set avg to 9, so e=9 gives s=-2
        drive(0, 9, 16'h0100, 16'h0000, 1); idle(4);
        expect_beat("alpha0", 32'h00400000, 1, 0, 7'h7E);

        // 512-beat frame with a 5-cycle output stall at beat 100
        do_reset(); clear();
        for (int i = 0; i < 512; i++) begin
            if (i == 100) begin
                m_tready = 1'b0;
                @(negedge clk);
                chk("stall_sready", s_tready, 0);
                repeat (5) @(posedge clk);
                #1 m_tready = 1'b1;
            end
            drive(i, 3, 16'(i * 4), 16'(-(i * 4)), i == 511);
        end
        idle(6);
        chk("burst_cnt", q_data.size(), 512);
        for (int i = 0; i < 512; i++)
            expect_beat("burst", {16'(i), 16'(-i)}, i == 511, 0, 7'h7E);

        // Mid-frame reset discards in-flight beats and re-primes
        do_reset(); clear();
        for (int i = 0; i < 50; i++) drive(i, 7, 16'h0100, 16'h0100, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_mvalid", m_tvalid, 0);
        chk("midrst_shift", cur_shift, 0);
        rst_n = 1'b1; clear();
        drive(0, 3, 16'h0100, 16'hFF00, 1); idle(4);
        expect_beat("reprime", 32'h0040FFC0, 1, 0, 7'h7E);
        chk("final_empty", q_data.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
